// File: rtl/dmem_io_timer_responder.sv
// Memory-mapped I/O responder for the LEGLite data bus: 7-segment display register,
// debounced slide switches and a prescaled countdown timer with a sticky expiry flag.
module dmem_io_timer_responder #(
    parameter logic [15:0] BASE     = 16'hFFF0,
    parameter int          DEBOUNCE = 4,
    parameter int          PRESCALE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] draddr,
    input  logic        dwrite,
    input  logic        dread,
    input  logic [15:0] dwdata,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [15:0] drdata,
    output logic        hit,
    output logic [6:0]  io_display,
    output logic        irq
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        OFF_DISP   = 2'd0,
        OFF_SW     = 2'd1,
        OFF_COUNT  = 2'd2,
        OFF_STATUS = 2'd3
    } reg_off_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } timer_state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    reg_off_e off;
    logic     wr_en;

    assign hit   = (draddr[15:2] == BASE[15:2]);
    assign off   = reg_off_e'(draddr[1:0]);
    assign wr_en = dwrite && hit;

    // ------------------------------------------------------------------
    // Display register
    // ------------------------------------------------------------------
    logic [6:0] disp_q, disp_d;

    always_comb begin
        disp_d = disp_q;
        if (wr_en && off == OFF_DISP) begin
            disp_d = dwdata[6:0];
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [1:0]           sw_raw;
    logic [1:0]           sw_meta_q, sw_sync_q;
    logic [1:0]           sw_db_q, sw_db_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    assign sw_raw = {io_sw1, io_sw0};

    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        sw_db_d  = sw_db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sw_sync_q[i] != sw_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    sw_db_d[i] = sw_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Countdown timer
    // ------------------------------------------------------------------
    timer_state_e    state_q, state_d;
    logic [15:0]     count_q, count_d;
    logic [PS_W-1:0] pre_q, pre_d;
    logic            expired_q, expired_d;
    logic            expire_evt;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        expired_d  = expired_q;
        expire_evt = 1'b0;

        // A COUNT store overrides any decrement due in the same cycle.
        if (wr_en && off == OFF_COUNT) begin
            count_d = dwdata;
            pre_d   = '0;
            state_d = (dwdata != 16'd0) ? S_RUN : S_IDLE;
        end else if (state_q == S_RUN) begin
            if (pre_q == PS_LAST) begin
                pre_d = '0;
                if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end
                if (count_q <= 16'd1) begin
                    expire_evt = 1'b1;
                    state_d    = S_IDLE;
                end
            end else begin
                pre_d = pre_q + PS_W'(1);
            end
        end

        if (wr_en && off == OFF_STATUS && dwdata[0]) begin
            expired_d = 1'b0;
        end
        if (expire_evt) begin
            expired_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_db_q   <= '0;
            db_cnt_q  <= '0;
            state_q   <= S_IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            disp_q    <= disp_d;
            sw_meta_q <= sw_raw;
            sw_sync_q <= sw_meta_q;
            sw_db_q   <= sw_db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency read path; forced to zero so it can be ORed with RAM data
    // ------------------------------------------------------------------
    logic [15:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_DISP:   rd_val = {9'd0, disp_q};
            OFF_SW:     rd_val = {14'd0, sw_db_q};
            OFF_COUNT:  rd_val = count_q;
            OFF_STATUS: rd_val = {14'd0, (state_q == S_RUN), expired_q};
            default:    rd_val = '0;
        endcase
        drdata = (dread && hit) ? rd_val : 16'd0;
    end

    assign io_display = disp_q;
    assign irq        = expired_q;

endmodule

// File: tb/tb_dmem_io_timer_responder.sv
// Scoreboard bench: the driver pushes expected outputs from a cycle-count based
// reference model; a negedge monitor pops and compares them against the DUT.
module tb_dmem_io_timer_responder;

    localparam int          DEBOUNCE = 4;
    localparam int          PRESCALE = 4;
    localparam logic [15:0] BASE     = 16'hFFF0;

    logic        clock;
    logic        reset;
    logic [15:0] draddr;
    logic        dwrite;
    logic        dread;
    logic [15:0] dwdata;
    logic        io_sw0;
    logic        io_sw1;
    logic [15:0] drdata;
    logic        hit;
    logic [6:0]  io_display;
    logic        irq;

    dmem_io_timer_responder #(
        .BASE(BASE), .DEBOUNCE(DEBOUNCE), .PRESCALE(PRESCALE)
    ) dut (
        .clock(clock), .reset(reset), .draddr(draddr), .dwrite(dwrite),
        .dread(dread), .dwdata(dwdata), .io_sw0(io_sw0), .io_sw1(io_sw1),
        .drdata(drdata), .hit(hit), .io_display(io_display), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] rd;
        logic        hit;
        logic [6:0]  disp;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: the timer is "cycles remaining until expiry"; the visible
    // count is that figure divided by PRESCALE, rounded up.
    int         rem;
    bit         expired_m;
    bit [6:0]   disp_m;
    bit         meta_m[2], sync_m[2], db_m[2];
    logic [31:0] hist[2];
    int         nvalid[2];

    function automatic void model_reset();
        rem = 0; expired_m = 0; disp_m = '0;
        for (int i = 0; i < 2; i++) begin
            meta_m[i] = 0; sync_m[i] = 0; db_m[i] = 0; hist[i] = '0; nvalid[i] = 0;
        end
    endfunction

    function automatic logic [15:0] reg_val(input logic [1:0] o);
        bit run;
        run = (rem > 0);
        case (o)
            2'd0:    return {9'd0, disp_m};
            2'd1:    return {14'd0, db_m[1], db_m[0]};
            2'd2:    return 16'((rem + PRESCALE - 1) / PRESCALE);
            default: return {14'd0, run, expired_m};
        endcase
    endfunction

    function automatic void model_edge();
        bit          h, wr, expire_now;
        logic [1:0]  o;
        logic [31:0] mask;
        bit          raw[2];
        h  = (draddr[15:2] == BASE[15:2]);
        o  = draddr[1:0];
        wr = dwrite && h;
        expire_now = (rem == 1) && !(wr && o == 2'd2);
        if (wr && o == 2'd0) disp_m = dwdata[6:0];
        if (wr && o == 2'd2) rem = int'(dwdata) * PRESCALE;
        else if (rem > 0)    rem--;
        if (wr && o == 2'd3 && dwdata[0]) expired_m = 0;
        if (expire_now) expired_m = 1;

        // A switch flips once the last DEBOUNCE synchronized samples all disagree with it.
        mask = (32'd1 << DEBOUNCE) - 32'd1;
        raw[0] = io_sw0; raw[1] = io_sw1;
        for (int i = 0; i < 2; i++) begin
            hist[i] = {hist[i][30:0], sync_m[i]};
            if (nvalid[i] < 32) nvalid[i]++;
            if (nvalid[i] >= DEBOUNCE &&
                ((db_m[i] && (hist[i] & mask) == 32'd0) ||
                 (!db_m[i] && (hist[i] & mask) == mask)))
                db_m[i] = !db_m[i];
            sync_m[i] = meta_m[i];
            meta_m[i] = raw[i];
        end
    endfunction

    task automatic step();
        exp_t e;
        e.hit  = (draddr[15:2] == BASE[15:2]);
        e.rd   = (dread && e.hit) ? reg_val(draddr[1:0]) : 16'h0000;
        e.disp = disp_m;
        e.irq  = expired_m;
        exp_q.push_back(e);
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic acc(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data);
        dread = rd; dwrite = wr; draddr = addr; dwdata = data;
        step();
    endtask

    task automatic rd_n(input logic [15:0] addr, input int n);
        for (int k = 0; k < n; k++) acc(1'b1, 1'b0, addr, 16'h0000);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("hit",     {15'd0, hit},   {15'd0, e.hit});
            check("drdata",  drdata,         e.rd);
            check("display", {9'd0, io_display}, {9'd0, e.disp});
            check("irq",     {15'd0, irq},   {15'd0, e.irq});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        reset = 1'b1; dread = 0; dwrite = 0; draddr = '0; dwdata = '0;
        io_sw0 = 0; io_sw1 = 0;
        model_reset();
        @(posedge clock); #1;
        rd_n(16'hFFF3, 1);
        rd_n(16'hFFF2, 1);
        reset = 1'b0;

        // Display register and out-of-window access
        acc(1'b0, 1'b1, 16'hFFF0, 16'h0079);
        rd_n(16'hFFF0, 1);
        rd_n(16'hFFF4, 1);

        // Timer run to expiry, then clear
        acc(1'b0, 1'b1, 16'hFFF2, 16'd3);
        rd_n(16'hFFF3, 14);
        rd_n(16'hFFF2, 1);
        acc(1'b0, 1'b1, 16'hFFF3, 16'h0001);
        rd_n(16'hFFF3, 1);

        // Reload on the cycle that would have expired
        acc(1'b0, 1'b1, 16'hFFF2, 16'd1);
        rd_n(16'hFFF3, 3);
        acc(1'b0, 1'b1, 16'hFFF2, 16'd5);
        rd_n(16'hFFF2, 1);
        rd_n(16'hFFF3, 22);

        // Status clear on the expiry cycle
        acc(1'b0, 1'b1, 16'hFFF2, 16'd1);
        rd_n(16'hFFF3, 3);
        acc(1'b0, 1'b1, 16'hFFF3, 16'h0001);
        rd_n(16'hFFF3, 1);
        acc(1'b0, 1'b1, 16'hFFF3, 16'h0001);

        // Writing zero stops the timer without expiry
        acc(1'b0, 1'b1, 16'hFFF2, 16'd7);
        rd_n(16'hFFF2, 3);
        acc(1'b0, 1'b1, 16'hFFF2, 16'd0);
        rd_n(16'hFFF3, 40);

        // Debounce with a glitch
        io_sw0 = 1; rd_n(16'hFFF1, 10);
        io_sw0 = 0; rd_n(16'hFFF1, 2);
        io_sw0 = 1; rd_n(16'hFFF1, 2);
        io_sw0 = 0; rd_n(16'hFFF1, 10);

        // Asynchronous reset while the timer runs
        acc(1'b0, 1'b1, 16'hFFF2, 16'd20);
        rd_n(16'hFFF2, 5);
        reset = 1'b1;
        model_reset();
        rd_n(16'hFFF3, 1);
        rd_n(16'hFFF2, 1);
        reset = 1'b0;
        rd_n(16'hFFF2, 1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] a, d;
            bit          w;
            if ($urandom_range(0, 99) < 80) a = BASE + 16'($urandom_range(0, 3));
            else                            a = 16'($urandom);
            w = ($urandom_range(0, 99) < 15);
            if (a[1:0] == 2'd2) d = 16'($urandom_range(0, 6));
            else                d = 16'($urandom);
            if ($urandom_range(0, 99) < 5) io_sw0 = ~io_sw0;
            if ($urandom_range(0, 99) < 5) io_sw1 = ~io_sw1;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                acc(1'($urandom), 1'b0, a, d);
                reset = 1'b0;
            end else begin
                acc(1'($urandom), w, a, d);
            end
        end
        dread = 0; dwrite = 0;

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
